// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package   : uart_pkg
// Purpose   : Shared UART types, widths and helpers (receiver and transmitter)
// Revision  : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Receiver/transmitter frame states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module    : sync_fifo
// Purpose   : First-word-fall-through FIFO with separate occupancy counter,
//             flush input where a coincident push survives the flush
// Revision  : 1.0 - initial release
// ============================================================================
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]          rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;
  // Head is forced to zero when empty so the output is defined out of reset
  assign rdata = empty ? '0 : mem[rd_ptr];

  // A flush discards the pop; a push is accepted when there is room, when a
  // pop frees a slot in the same cycle, or when a flush empties the FIFO
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop | clear);

  // Storage write; contents need no reset because reads are gated by empty
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (clear) begin
        rd_ptr <= wr_ptr;
        cnt    <= do_push ? CW'(1) : '0;
      end else begin
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module    : uart_rx_fifo
// Purpose   : 8N1 UART receiver with input synchroniser, framing check,
//             sticky error flags, receive FIFO and level interrupt
// Revision  : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          rx_i,
  input  logic                          clear_i,
  output logic [UART_DATA_W-1:0]        rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          irq_o,
  output logic                          overrun_o,
  output logic                          frame_err_o
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [BW-1:0] HALF_BIT = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_BIT = BW'(BAUD_DIV - 1);

  logic                   rx_meta;
  logic                   rxs;
  uart_state_e            state, state_n;
  logic [BW-1:0]          bcnt, bcnt_n;
  logic [2:0]             bitn, bitn_n;
  logic [UART_DATA_W-1:0] shreg, shreg_n;
  logic                   push;
  logic                   frame_set;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  // Frame state, baud and bit counters, and shift register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      bcnt  <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
    end
  end

  // Next-state logic: sample each bit mid-cell, LSB first
  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    bitn_n    = bitn;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          bcnt_n  = HALF_BIT;
        end
      end
      START: begin
        if (bcnt != '0) begin
          bcnt_n = bcnt - 1'b1;
        end else if (rxs) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          bcnt_n  = FULL_BIT;
          bitn_n  = '0;
        end
      end
      DATA: begin
        if (bcnt != '0) begin
          bcnt_n = bcnt - 1'b1;
        end else begin
          shreg_n = {rxs, shreg[UART_DATA_W-1:1]};
          bcnt_n  = FULL_BIT;
          bitn_n  = bitn + 1'b1;
          if (bitn == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (bcnt != '0) begin
          bcnt_n = bcnt - 1'b1;
        end else if (rxs) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          frame_set = 1'b1;
          state_n   = BREAK;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop = rx_valid_o & rx_ready_i;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetb (resetb),
    .push   (push),
    .pop    (pop),
    .clear  (clear_i),
    .wdata  (shreg),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .rdata  (rx_data_o)
  );

  assign rx_valid_o   = ~fifo_empty;
  assign fifo_count_o = fifo_count;

  // Sticky flags: a new error in the flush cycle is kept, older ones cleared
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (push & fifo_full & ~pop & ~clear_i) begin
        overrun_o <= 1'b1;
      end else if (clear_i) begin
        overrun_o <= 1'b0;
      end
      if (frame_set) begin
        frame_err_o <= 1'b1;
      end else if (clear_i) begin
        frame_err_o <= 1'b0;
      end
    end
  end

  // Level interrupt, registered one cycle behind the occupancy count
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (fifo_count >= CW'(IRQ_LEVEL));
    end
  end

endmodule
`default_nettype wire
